temporizador: RTL and testbench
===============================

TEMPORIZADOR -- requirements
Module: temporizador

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 50000000, meaning clk cycles per one-second countdown tick (minimum 2).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The module SHALL have port botoes, input, [0:3], active-low pushbuttons: 0 start/pause, 1 reload, 2 minute increment, 3 second increment.
REQ-005 The module SHALL have port led, output, [0:3], one-hot state indication: 0 RUN, 1 PAUSE, 2 DONE, 3 IDLE.
REQ-006 The module SHALL have ports dis0, dis1, dis2, dis3, output, [0:6] each, active-low 7-segment codes (bit 0 = segment a ... bit 6 = segment g) for seconds units, seconds tens, minutes units and minutes tens respectively.

Function
REQ-007 Each botoes bit SHALL pass through a 2-flop synchroniser followed by a press-edge detector (1 to 0), giving a one-cycle pulse 3 cycles after the pin falls; holding a button SHALL produce exactly one pulse.
REQ-008 Time SHALL be held as four BCD digits MM:SS, range 00:00 to 59:59; a preset register SHALL hold the last value set in IDLE.
REQ-009 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-010 IDLE: inc-minute pulse SHALL advance MM by 1 (59 wraps to 00, SS unchanged); inc-second pulse SHALL advance SS by 1 (59 wraps to 00, no carry into MM); preset SHALL track the time.
REQ-011 IDLE + start with time not 00:00 SHALL go to RUN and clear the prescaler; start with time 00:00 SHALL be ignored.
REQ-012 RUN: the prescaler SHALL count 0..CLK_HZ-1; on the cycle it equals CLK_HZ-1, time SHALL decrement by one second (SS 00 borrows: SS becomes 59, MM decrements).
REQ-013 When a decrement produces 00:00, the FSM SHALL enter DONE on that same edge.
REQ-014 RUN + start SHALL go to PAUSE; PAUSE + start SHALL return to RUN; the prescaler SHALL freeze in PAUSE and resume without clearing.
REQ-015 Reload pulse in any state SHALL go to IDLE, load time from preset and clear the prescaler; in DONE only reload leaves the state.
REQ-016 Increment pulses outside IDLE SHALL be ignored.
REQ-017 Simultaneous pulses SHALL be resolved with priority reload > start > inc-minute > inc-second; lower-priority pulses in that cycle are discarded.
REQ-018 A start pulse coinciding with the final tick SHALL be discarded: the FSM enters DONE.
REQ-019 Displays and led SHALL be registered outputs reflecting state and time one cycle after they change.

Reset
REQ-020 Asserting rst SHALL immediately force: state IDLE, time 00:00, preset 00:00, prescaler 0, synchroniser flops 1 (released), led 0001, dis0..dis3 all 0000001 (digit 0).
REQ-021 Reset mid-RUN SHALL discard the countdown and preset; no pulse SHALL be generated by rst release while buttons are held.

Configuration
REQ-022 Macro DONE_BLINK_EN SHALL, when defined, blank all four displays (1111111) during alternating CLK_HZ/2-cycle halves while in DONE, starting blanked on DONE entry; when undefined, DONE displays show 00:00 steadily.

Structure
REQ-023 Package temporizador_pkg SHALL hold the state enumeration, the BCD digit type and the 7-segment code constants for digits 0-9 and blank.
REQ-024 One sub-module, seg7_bcd, SHALL map one BCD digit to a 7-segment code and be instantiated four times.

Verification (CLK_HZ = 4)
REQ-025 Reset then press botoes[2] twice and botoes[3] once -> displays 02:01, led 0001.
REQ-026 From 00:02 press start -> led 1000; after 4 cycles 00:01, after 8 cycles 00:00 and led 0010.
REQ-027 Seconds borrow: from 01:00 in RUN -> after one tick 00:59.
REQ-028 Pause after 2 RUN cycles, hold 10 cycles, resume -> next decrement after 2 further RUN cycles; time unchanged during PAUSE.
REQ-029 Reload and start pressed together in RUN from preset 00:03 -> IDLE, 00:03, led 0001; increments at 59:59 wrap to 00:00 with no carry.
REQ-030 With DONE_BLINK_EN, DONE -> displays blank 2 cycles, show 00:00 for 2 cycles, repeating; rst asserted mid-RUN -> outputs at reset values without waiting for clk.

Source files
------------

// File: rtl/temporizador_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | temporizador_pkg                                                    |
// | State enumeration, BCD time types, 7-segment codes and BCD helpers. |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
package temporizador_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;
    typedef logic [0:6] seg_t;

    typedef struct packed {
        bcd_t t;
        bcd_t u;
    } bcd2_t;

    typedef struct packed {
        bcd2_t mm;
        bcd2_t ss;
    } mmss_t;

    // Active-low, ordered a..g from left to right.
    localparam seg_t C_SEG_0     = 7'b0000001;
    localparam seg_t C_SEG_1     = 7'b1001111;
    localparam seg_t C_SEG_2     = 7'b0010010;
    localparam seg_t C_SEG_3     = 7'b0000110;
    localparam seg_t C_SEG_4     = 7'b1001100;
    localparam seg_t C_SEG_5     = 7'b0100100;
    localparam seg_t C_SEG_6     = 7'b0100000;
    localparam seg_t C_SEG_7     = 7'b0001111;
    localparam seg_t C_SEG_8     = 7'b0000000;
    localparam seg_t C_SEG_9     = 7'b0000100;
    localparam seg_t C_SEG_BLANK = 7'b1111111;

    function automatic bcd2_t inc59(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.u == bcd_t'(9)) begin
            r.u = '0;
            r.t = (v.t == bcd_t'(5)) ? '0 : v.t + bcd_t'(1);
        end else begin
            r.u = v.u + bcd_t'(1);
        end
        return r;
    endfunction

    function automatic mmss_t dec_time(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.ss.u != '0) begin
            r.ss.u = v.ss.u - bcd_t'(1);
        end else begin
            r.ss.u = bcd_t'(9);
            if (v.ss.t != '0) begin
                r.ss.t = v.ss.t - bcd_t'(1);
            end else begin
                r.ss.t = bcd_t'(5);
                if (v.mm.u != '0) begin
                    r.mm.u = v.mm.u - bcd_t'(1);
                end else begin
                    r.mm.u = bcd_t'(9);
                    r.mm.t = v.mm.t - bcd_t'(1);
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/temporizador_seg7_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_bcd                                                            |
// | One BCD digit to active-low 7-segment code, with forced blanking.   |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module seg7_bcd
    import temporizador_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [0:6] o_seg
);

    always_comb begin
        o_seg = C_SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = C_SEG_0;
                4'd1:    o_seg = C_SEG_1;
                4'd2:    o_seg = C_SEG_2;
                4'd3:    o_seg = C_SEG_3;
                4'd4:    o_seg = C_SEG_4;
                4'd5:    o_seg = C_SEG_5;
                4'd6:    o_seg = C_SEG_6;
                4'd7:    o_seg = C_SEG_7;
                4'd8:    o_seg = C_SEG_8;
                4'd9:    o_seg = C_SEG_9;
                default: o_seg = C_SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/temporizador.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | temporizador                                                        |
// | MM:SS countdown timer with pushbuttons, LEDs and 7-segment outputs. |
// | Optional macro DONE_BLINK_EN blinks the displays while in DONE.     |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module temporizador
    import temporizador_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:3] botoes,
    output logic [0:3] led,
    output logic [0:6] dis0,
    output logic [0:6] dis1,
    output logic [0:6] dis2,
    output logic [0:6] dis3
);

    localparam int             PW       = $clog2(CLK_HZ);
    localparam logic [PW-1:0] C_PRE_LAST = PW'(CLK_HZ - 1);
`ifdef DONE_BLINK_EN
    localparam logic [PW-1:0] C_PRE_HALF = PW'(CLK_HZ / 2);
`endif

    logic [0:3]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, armed_q, armed_d;
    logic [1:0]    settle_q, settle_d;
    state_t        state_q, state_d;
    mmss_t         time_q, time_d, preset_q, preset_d, w_dec;
    logic [PW-1:0] pre_q, pre_d;
    logic [0:3]    led_q, led_d;
    seg_t          dis0_q, dis1_q, dis2_q, dis3_q, w_seg0, w_seg1, w_seg2, w_seg3;
    logic [0:3]    w_press;
    logic          w_reload, w_start, w_incm, w_incs, w_blank;

    // A button only arms once the synchroniser has seen it released after reset,
    // so a button held across rst release never yields a pulse.
    always_comb begin
        sync1_d  = botoes;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd2) ? sync2_q : 4'b0000);
        w_press  = armed_q & prev_q & ~sync2_q;
        w_reload = w_press[1];
        w_start  = w_press[0] & ~w_press[1];
        w_incm   = w_press[2] & ~w_press[1] & ~w_press[0];
        w_incs   = w_press[3] & ~w_press[2] & ~w_press[1] & ~w_press[0];
    end

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        preset_d = preset_q;
        pre_d    = pre_q;
        w_dec    = dec_time(time_q);
        if (w_reload) begin
            state_d = S_IDLE;
            time_d  = preset_q;
            pre_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        if (time_q != '0) begin
                            state_d = S_RUN;
                            pre_d   = '0;
                        end
                    end else if (w_incm) begin
                        time_d.mm = inc59(time_q.mm);
                    end else if (w_incs) begin
                        time_d.ss = inc59(time_q.ss);
                    end
                    preset_d = time_d;
                end
                S_RUN: begin
                    pre_d = (pre_q == C_PRE_LAST) ? '0 : pre_q + PW'(1);
                    if (pre_q == C_PRE_LAST) begin
                        time_d = w_dec;
                    end
                    // The final tick wins over a coincident start.
                    if (pre_q == C_PRE_LAST && w_dec == '0) begin
                        state_d = S_DONE;
                    end else if (w_start) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (w_start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
`ifdef DONE_BLINK_EN
                    pre_d = (pre_q == C_PRE_LAST) ? '0 : pre_q + PW'(1);
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_RUN:   led_d = 4'b1000;
            S_PAUSE: led_d = 4'b0100;
            S_DONE:  led_d = 4'b0010;
            default: led_d = 4'b0001;
        endcase
`ifdef DONE_BLINK_EN
        w_blank = (state_q == S_DONE) && (pre_q < C_PRE_HALF);
`else
        w_blank = 1'b0;
`endif
    end

    seg7_bcd u_seg0 (.i_digit(time_q.ss.u), .i_blank(w_blank), .o_seg(w_seg0));
    seg7_bcd u_seg1 (.i_digit(time_q.ss.t), .i_blank(w_blank), .o_seg(w_seg1));
    seg7_bcd u_seg2 (.i_digit(time_q.mm.u), .i_blank(w_blank), .o_seg(w_seg2));
    seg7_bcd u_seg3 (.i_digit(time_q.mm.t), .i_blank(w_blank), .o_seg(w_seg3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            prev_q   <= '1;
            armed_q  <= '0;
            settle_q <= '0;
            state_q  <= S_IDLE;
            time_q   <= '0;
            preset_q <= '0;
            pre_q    <= '0;
            led_q    <= 4'b0001;
            dis0_q   <= C_SEG_0;
            dis1_q   <= C_SEG_0;
            dis2_q   <= C_SEG_0;
            dis3_q   <= C_SEG_0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
            state_q  <= state_d;
            time_q   <= time_d;
            preset_q <= preset_d;
            pre_q    <= pre_d;
            led_q    <= led_d;
            dis0_q   <= w_seg0;
            dis1_q   <= w_seg1;
            dis2_q   <= w_seg2;
            dis3_q   <= w_seg3;
        end
    end

    assign led  = led_q;
    assign dis0 = dis0_q;
    assign dis1 = dis1_q;
    assign dis2 = dis2_q;
    assign dis3 = dis3_q;

endmodule
`default_nettype wire

// File: tb/tb_temporizador.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_temporizador                                                     |
// | Directed self-checking bench for temporizador with CLK_HZ = 4.      |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module tb_temporizador;

    logic       clk;
    logic       rst;
    logic [0:3] botoes;
    logic [0:3] led;
    logic [0:6] dis0, dis1, dis2, dis3;
    int         errors;
    int         checks;

    temporizador #(.CLK_HZ(4)) dut (
        .clk(clk), .rst(rst), .botoes(botoes), .led(led),
        .dis0(dis0), .dis1(dis1), .dis2(dis2), .dis3(dis3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk7(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_led(input string tag, input logic [3:0] exp);
        checks++;
        assert (led === exp) else begin
            errors++;
            $error("FAIL %s led observed=%b expected=%b", tag, led, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int mt, input int mu, input int st, input int su);
        chk7({tag, "/dis3"}, dis3, seg(mt));
        chk7({tag, "/dis2"}, dis2, seg(mu));
        chk7({tag, "/dis1"}, dis1, seg(st));
        chk7({tag, "/dis0"}, dis0, seg(su));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int i);
        botoes[i] = 1'b0;
        tick(4);
        botoes[i] = 1'b1;
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        botoes = 4'b1111;
        rst    = 1'b1;
        tick(3);
        chk_led("reset_led", 4'b0001);
        chk_time("reset_time", 0, 0, 0, 0);
        rst = 1'b0;
        tick(4);

        // Increments in IDLE
        press(2);
        press(2);
        press(3);
        chk_time("set_0201", 0, 2, 0, 1);
        chk_led("set_led", 4'b0001);

        // Countdown 00:02 -> DONE
        do_reset();
        press(3);
        press(3);
        botoes[0] = 1'b0;
        tick(3);
        chk_led("run_not_yet", 4'b0001);
        tick(1);
        chk_led("run_led", 4'b1000);
        botoes[0] = 1'b1;
        tick(3);
        chk_time("cd_before_tick", 0, 0, 0, 2);
        tick(1);
        chk_time("cd_0001", 0, 0, 0, 1);
        tick(3);
        chk_led("cd_still_run", 4'b1000);
        tick(1);
        chk_led("done_led", 4'b0010);
`ifdef DONE_BLINK_EN
        chk_time("blink_off_a", 10, 10, 10, 10);
        tick(1);
        chk_time("blink_off_b", 10, 10, 10, 10);
        tick(1);
        chk_time("blink_on_a", 0, 0, 0, 0);
        tick(1);
        chk_time("blink_on_b", 0, 0, 0, 0);
        tick(1);
        chk_time("blink_off_c", 10, 10, 10, 10);
`else
        chk_time("done_0000", 0, 0, 0, 0);
        tick(2);
        chk_time("done_steady", 0, 0, 0, 0);
`endif

        // DONE ignores start and increments, reload returns to preset
        press(0);
        chk_led("done_ign_start", 4'b0010);
        press(3);
        chk_led("done_ign_inc", 4'b0010);
        press(1);
        chk_led("reload_done_led", 4'b0001);
        chk_time("reload_done_time", 0, 0, 0, 2);

        // Seconds borrow 01:00 -> 00:59
        do_reset();
        press(2);
        press(0);
        tick(1);
        chk_time("borrow", 0, 0, 5, 9);
        chk_led("borrow_led", 4'b1000);

        // Pause after two RUN cycles, hold, resume
        press(1);
        chk_time("reload_0100", 0, 1, 0, 0);
        botoes[0] = 1'b0;
        tick(1);
        botoes[0] = 1'b1;
        tick(1);
        botoes[0] = 1'b0;
        tick(1);
        botoes[0] = 1'b1;
        tick(1);
        chk_led("p_run", 4'b1000);
        tick(2);
        chk_led("p_pause", 4'b0100);
        tick(9);
        chk_led("p_hold", 4'b0100);
        chk_time("p_hold_time", 0, 1, 0, 0);
        botoes[0] = 1'b0;
        tick(1);
        botoes[0] = 1'b1;
        tick(3);
        chk_led("p_resume", 4'b1000);
        chk_time("p_resume_time", 0, 1, 0, 0);
        tick(1);
        chk_time("p_no_early_dec", 0, 1, 0, 0);
        tick(1);
        chk_time("p_dec", 0, 0, 5, 9);

        // Reload and start together in RUN
        do_reset();
        press(3);
        press(3);
        press(3);
        press(0);
        chk_led("rs_run", 4'b1000);
        botoes[0] = 1'b0;
        botoes[1] = 1'b0;
        tick(4);
        botoes[0] = 1'b1;
        botoes[1] = 1'b1;
        tick(3);
        chk_led("rs_led", 4'b0001);
        chk_time("rs_time", 0, 0, 0, 3);

        // Wrap at 59:59 without carry, start at 00:00 ignored
        do_reset();
        for (int k = 0; k < 59; k++) press(2);
        for (int k = 0; k < 59; k++) press(3);
        chk_time("max_5959", 5, 9, 5, 9);
        press(3);
        chk_time("wrap_sec", 5, 9, 0, 0);
        press(2);
        chk_time("wrap_min", 0, 0, 0, 0);
        press(0);
        chk_led("start_zero_ign", 4'b0001);

        // Asynchronous reset mid-RUN, held button across release
        press(2);
        press(0);
        chk_led("mid_run", 4'b1000);
        rst = 1'b1;
        #1;
        chk_led("async_rst_led", 4'b0001);
        chk_time("async_rst_time", 0, 0, 0, 0);
        botoes[3] = 1'b0;
        #2;
        rst = 1'b0;
        tick(6);
        chk_time("held_no_pulse", 0, 0, 0, 0);
        botoes[3] = 1'b1;
        tick(3);
        press(3);
        chk_time("post_rst_inc", 0, 0, 0, 1);

        // inc-minute beats inc-second in the same cycle
        botoes[2] = 1'b0;
        botoes[3] = 1'b0;
        tick(4);
        botoes[2] = 1'b1;
        botoes[3] = 1'b1;
        tick(3);
        chk_time("prio_min", 0, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
